// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: NUM_REQ producers share one FIFO write port,
// each grant covers a burst of up to BURST_LEN words with FULL backpressure.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BUS_WIDTH = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                           CLK,
  input  logic                           RSTn,
  input  logic [NUM_REQ-1:0]             REQ,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]   REQ_DATA,
  output logic [NUM_REQ-1:0]             GNT,
  output logic [NUM_REQ-1:0]             ACK,
  input  logic                           FIFO_FULL,
  output logic                           FIFO_WR_EN,
  output logic [BUS_WIDTH-1:0]           FIFO_DATA_IN,
  output logic                           BUSY
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]        last_q, last_d;
  logic [CW-1:0]        beat_q, beat_d;
  logic                 busy_q, busy_d;

  logic                 req_g, accept;
  logic                 win_vld;
  logic [PW-1:0]        win;
  logic [BUS_WIDTH-1:0] data_mux;

  assign req_g      = |(REQ & gnt_q);
  assign accept     = req_g & ~FIFO_FULL;
  assign ACK        = gnt_q & REQ & {NUM_REQ{~FIFO_FULL}};
  assign FIFO_WR_EN = accept;
  assign GNT        = gnt_q;
  assign BUSY       = busy_q;

  // grant is one-hot, so a priority-free OR-mux yields the granted slice or 0
  always_comb begin
    data_mux = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_q[i]) data_mux = data_mux | REQ_DATA[i*BUS_WIDTH +: BUS_WIDTH];
  end
  assign FIFO_DATA_IN = data_mux;

  // scan downward so the requester closest after last_q wins
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win     = '0;
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (REQ[idx]) begin
        win_vld = 1'b1;
        win     = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    beat_d  = beat_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_GRANT;
          gnt_d   = NUM_REQ'(1) << win;
          last_d  = win;
          beat_d  = '0;
          busy_d  = 1'b1;
        end
      end
      S_GRANT: begin
        if (!req_g || (accept && beat_q == LAST_BEAT)) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          beat_d  = '0;
          busy_d  = 1'b0;
        end else if (accept) begin
          beat_d  = beat_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        beat_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= PW'(NUM_REQ - 1);
      beat_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a grant/burst reference model.
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int B = 4;

  logic           CLK = 1'b0;
  logic           RSTn;
  logic [N-1:0]   REQ;
  logic [N*W-1:0] REQ_DATA;
  logic [N-1:0]   GNT, ACK;
  logic           FIFO_FULL;
  logic           FIFO_WR_EN;
  logic [W-1:0]   FIFO_DATA_IN;
  logic           BUSY;

  fifo_wr_arbiter #(.NUM_REQ(N), .BUS_WIDTH(W), .BURST_LEN(B)) dut (
    .CLK(CLK), .RSTn(RSTn), .REQ(REQ), .REQ_DATA(REQ_DATA), .GNT(GNT), .ACK(ACK),
    .FIFO_FULL(FIFO_FULL), .FIFO_WR_EN(FIFO_WR_EN), .FIFO_DATA_IN(FIFO_DATA_IN), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  logic [W-1:0] cur [N];
  always_comb begin
    REQ_DATA = '0;
    for (int i = 0; i < N; i++) REQ_DATA[i*W +: W] = cur[i];
  end

  int n_chk = 0;
  int n_err = 0;

  // model: granted requester (-1 = idle), round-robin pointer, words this grant
  int           m_g, m_last, m_beats, cyc;
  logic [N-1:0] m_ack;
  logic [W-1:0] wr_log[$];
  int           wr_cyc[$];
  logic [N-1:0] gnt_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_g = -1; m_last = N - 1; m_beats = 0; m_ack = '0;
    wr_log.delete(); wr_cyc.delete(); gnt_log.delete();
  endtask

  // check this cycle's outputs, then advance the model across the clock edge
  task automatic step();
    logic [N-1:0] eg;
    logic         acc;
    logic [W-1:0] ed;
    #1;
    eg = '0; ed = '0; acc = 1'b0;
    if (m_g >= 0) begin
      eg[m_g] = 1'b1;
      ed      = cur[m_g];
      acc     = REQ[m_g] && !FIFO_FULL;
    end
    m_ack = acc ? eg : '0;
    chk("gnt",  32'(GNT), 32'(eg));
    chk("busy", 32'(BUSY), 32'(m_g >= 0));
    chk("ack",  32'(ACK), 32'(m_ack));
    chk("wr",   32'(FIFO_WR_EN), 32'(acc));
    chk("data", 32'(FIFO_DATA_IN), 32'(ed));
    if (acc) begin wr_log.push_back(cur[m_g]); wr_cyc.push_back(cyc); end
    @(posedge CLK);
    cyc++;
    if (m_g < 0) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (REQ[idx]) begin
          m_g = idx; m_last = idx; m_beats = 0;
          gnt_log.push_back(N'(1) << idx);
          break;
        end
      end
    end else if (!REQ[m_g]) begin
      m_g = -1;
    end else if (acc) begin
      m_beats++;
      if (m_beats == B) m_g = -1;
    end
    #1;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    #1;
    chk("rst_gnt", 32'(GNT), 0);
    chk("rst_ack", 32'(ACK), 0);
    chk("rst_wr",  32'(FIFO_WR_EN), 0);
    chk("rst_busy", 32'(BUSY), 0);
    model_reset();
    @(posedge CLK); #2;
    RSTn = 1'b1;
  endtask

  initial begin
    int n;
    cyc = 0;
    for (int i = 0; i < N; i++) cur[i] = '0;
    REQ = '0; FIFO_FULL = 1'b0; RSTn = 1'b1;
    model_reset();

    // 1: reset with random requests, then all request -> requester 0 first
    REQ = 4'($urandom);
    do_reset();
    REQ = 4'b1111;
    step();
    chk("t1_first", 32'(GNT), 32'(4'b0001));
    REQ = '0; step(); step(); step(); step(); step();

    // 2: single requester, six words, burst split by one bubble
    do_reset();
    wr_log.delete(); wr_cyc.delete();
    cur[0] = 8'h10; REQ = 4'b0001;
    n = 0;
    while (cur[0] != 8'h16 && n < 40) begin
      step(); n++;
      if (m_ack[0]) cur[0] = cur[0] + 8'h1;
      if (cur[0] == 8'h16) REQ = '0;
    end
    chk("t2_bound", 32'(n < 40), 1);
    chk("t2_cnt", 32'(wr_log.size()), 6);
    if (wr_log.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t2_word", 32'(wr_log[i]), 32'(8'h10 + i));
      chk("t2_b2b",   32'(wr_cyc[3] - wr_cyc[0]), 3);
      chk("t2_gap",   32'(wr_cyc[4] - wr_cyc[3]), 2);
    end
    step();

    // 3: everyone requesting -> rotating grants, bursts of 4
    do_reset();
    REQ = 4'b1111;
    for (int c = 0; c < 26; c++) begin
      step();
      for (int i = 0; i < N; i++) if (m_ack[i]) cur[i] = cur[i] + 8'h1;
    end
    chk("t3_ngnt", 32'(gnt_log.size() >= 5), 1);
    if (gnt_log.size() >= 5) begin
      chk("t3_g0", 32'(gnt_log[0]), 32'(4'b0001));
      chk("t3_g1", 32'(gnt_log[1]), 32'(4'b0010));
      chk("t3_g2", 32'(gnt_log[2]), 32'(4'b0100));
      chk("t3_g3", 32'(gnt_log[3]), 32'(4'b1000));
      chk("t3_g4", 32'(gnt_log[4]), 32'(4'b0001));
    end
    chk("t3_words", 32'(wr_log.size()), 20);
    REQ = '0; step();

    // 4: FULL stalls requester 2 after its first beat
    do_reset();
    REQ = 4'b0100; cur[2] = 8'h40;
    step();
    step(); if (m_ack[2]) cur[2]++;
    FIFO_FULL = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t4_nowr", 32'(FIFO_WR_EN), 0);
    end
    FIFO_FULL = 1'b0;
    for (int c = 0; c < 3; c++) begin step(); if (m_ack[2]) cur[2]++; end
    REQ = '0; step();
    chk("t4_words", 32'(wr_log.size()), 4);

    // 5: requester 1 drops after two beats, requester 3 follows
    do_reset();
    REQ = 4'b1010;
    step();
    for (int c = 0; c < 2; c++) begin step(); if (m_ack[1]) cur[1]++; end
    REQ = 4'b1000;
    step();
    chk("t5_drop", 32'(GNT), 0);
    step();
    chk("t5_next", 32'(GNT), 32'(4'b1000));
    REQ = '0; step(); step();

    // 6: asynchronous reset mid-burst
    do_reset();
    REQ = 4'b0100;
    step(); step();
    #2 RSTn = 1'b0;
    #1 chk("t6_async", 32'(GNT), 0);
    model_reset();
    REQ = 4'b0101;
    @(posedge CLK); #2 RSTn = 1'b1;
    step();
    chk("t6_after", 32'(GNT), 32'(4'b0001));
    REQ = '0; step(); step();

    // random traffic with backpressure and occasional forfeits
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (m_ack[i]) begin
          cur[i] = W'($urandom);
          REQ[i] = ($urandom_range(0, 99) < 60);
        end else if (REQ[i]) begin
          if ($urandom_range(0, 99) < 3) REQ[i] = 1'b0;
        end else begin
          REQ[i] = ($urandom_range(0, 99) < 40);
          cur[i] = W'($urandom);
        end
      end
      FIFO_FULL = ($urandom_range(0, 99) < 25);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
